// File: rtl/qspi_mem_arbiter.sv
// Two-port arbiter in front of the tinyQV QSPI memory controller: data load/store has priority,
// and a starvation counter forces an instruction-fetch grant after MAX_WAIT data grants.
module qspi_mem_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_ready,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       settle;
  logic       pick_data;

  // The ready cycle is spent idle: the finished requester still holds req there,
  // so arbitrating in it would re-grant a request that has already completed.
  assign settle    = instr_ready | data_ready;
  assign pick_data = data_req && (!instr_req || starve_cnt != MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant_data  <= 1'b0;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      instr_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!settle && (instr_req || data_req)) begin
            state      <= S_ISSUE;
            mem_valid  <= 1'b1;
            grant_data <= pick_data;
            if (pick_data) begin
              mem_we    <= data_we;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              if (instr_req && starve_cnt < MAX_CNT) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= instr_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            state <= S_IDLE;
            if (grant_data) begin
              data_rdata <= mem_rdata;
              data_ready <= 1'b1;
            end else begin
              instr_rdata <= mem_rdata;
              instr_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
